// File: rtl/mem_write_buffer.sv
// mem_write_buffer
//
// Posted-write buffer between the cache's memory-side port and main memory.
// Stores from the cache are acknowledged one cycle after acceptance and
// parked in a small circular FIFO. A downstream FSM drains them to memory
// in order. Reads are held until every older store has reached memory, so
// read-after-write ordering is preserved.
//
// Optional feature (macro WBUF_FWD_EN):
//   When defined, a read whose word address matches a buffered full-word
//   store (wstrb == 4'hF) is answered directly from the youngest matching
//   entry, one cycle after acceptance, with no memory access. If the
//   youngest match is a partial store, the read falls back to
//   drain-then-read. When undefined, no address comparators are built and
//   every read waits for the buffer to empty.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   mem_valid/instr/addr/
//   mem_wdata/wstrb            request from the cache (wstrb == 0 is a read)
//   mem_ready, mem_rdata       one-cycle completion pulse and read data
//   mem_valid_m/instr_m/addr_m/
//   mem_wdata_m/wstrb_m        request to memory
//   mem_ready_m, mem_rdata_m   completion pulse and read data from memory
//   wb_count/wb_full/wb_empty  registered buffer occupancy status

module mem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_valid,
    input  logic                    mem_instr,
    input  logic [AW-1:0]           mem_addr,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_wstrb,
    output logic                    mem_ready,
    output logic [31:0]             mem_rdata,
    output logic                    mem_valid_m,
    output logic                    mem_instr_m,
    output logic [AW-1:0]           mem_addr_m,
    output logic [31:0]             mem_wdata_m,
    output logic [3:0]              mem_wstrb_m,
    input  logic                    mem_ready_m,
    input  logic [31:0]             mem_rdata_m,
    output logic [$clog2(DEPTH):0]  wb_count,
    output logic                    wb_full,
    output logic                    wb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state_q, state_d;

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;

    logic [AW-1:0]   buf_addr_q  [DEPTH];
    logic [AW-1:0]   buf_addr_d  [DEPTH];
    logic [31:0]     buf_wdata_q [DEPTH];
    logic [31:0]     buf_wdata_d [DEPTH];
    logic [3:0]      buf_wstrb_q [DEPTH];
    logic [3:0]      buf_wstrb_d [DEPTH];

    logic            valid_m_q, valid_m_d;
    logic            instr_m_q, instr_m_d;
    logic [AW-1:0]   addr_m_q,  addr_m_d;
    logic [31:0]     wdata_m_q, wdata_m_d;
    logic [3:0]      wstrb_m_q, wstrb_m_d;

    logic            ready_q, ready_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            read_req;
    logic            store_accept;
    logic            read_issue;
    logic            deq;
    logic            fwd_accept;
    logic [31:0]     fwd_data;

    // Upstream acceptance. The cache holds a request until it sees
    // mem_ready, so nothing is accepted while mem_ready is high; that keeps
    // the same held request from being taken twice. Stores only look at the
    // registered full flag, so a dequeue in the same cycle does not open a
    // slot until the next cycle.
    always_comb begin
        read_req     = mem_valid && (mem_wstrb == 4'h0);
        store_accept = mem_valid && (mem_wstrb != 4'h0) && !full_q && !ready_q;
        read_issue   = read_req && !ready_q && empty_q && (state_q == IDLE);
    end

`ifdef WBUF_FWD_EN
    logic            fwd_full;
    logic [PW-1:0]   fwd_idx;

    // Scan occupied entries from oldest to youngest so the last match wins.
    // Only a youngest match that covers the whole word can be forwarded;
    // a younger partial store must reach memory first.
    always_comb begin
        fwd_full = 1'b0;
        fwd_data = '0;
        fwd_idx  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) &&
                (buf_addr_q[fwd_idx][AW-1:2] == mem_addr[AW-1:2])) begin
                fwd_full = (buf_wstrb_q[fwd_idx] == 4'hF);
                fwd_data = buf_wdata_q[fwd_idx];
            end
        end
        fwd_accept = read_req && !ready_q && fwd_full &&
                     ((state_q == IDLE) || (state_q == WR));
    end
`else
    // Without forwarding every read goes through memory.
    always_comb begin
        fwd_accept = 1'b0;
        fwd_data   = '0;
    end
`endif

    // FIFO bookkeeping: write the tail entry on an accepted store, advance
    // the head when the FSM retires a write, and precompute the status
    // flags so they can be registered alongside the count.
    always_comb begin
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        buf_wstrb_d = buf_wstrb_q;
        if (store_accept) begin
            buf_addr_d[tail_q]  = mem_addr;
            buf_wdata_d[tail_q] = mem_wdata;
            buf_wstrb_d[tail_q] = mem_wstrb;
        end
        tail_d  = store_accept ? tail_q + PW'(1) : tail_q;
        head_d  = deq ? head_q + PW'(1) : head_q;
        count_d = count_q + CW'(store_accept) - CW'(deq);
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Downstream FSM. Buffered stores win over a waiting read. Every memory
    // request passes back through IDLE, which guarantees at least one idle
    // cycle between requests and lets the registered empty flag settle
    // before a read is considered.
    always_comb begin
        state_d   = state_q;
        valid_m_d = valid_m_q;
        instr_m_d = instr_m_q;
        addr_m_d  = addr_m_q;
        wdata_m_d = wdata_m_q;
        wstrb_m_d = wstrb_m_q;
        deq       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    state_d   = WR;
                    valid_m_d = 1'b1;
                    instr_m_d = 1'b0;
                    addr_m_d  = buf_addr_q[head_q];
                    wdata_m_d = buf_wdata_q[head_q];
                    wstrb_m_d = buf_wstrb_q[head_q];
                end else if (read_issue) begin
                    state_d   = RD;
                    valid_m_d = 1'b1;
                    instr_m_d = mem_instr;
                    addr_m_d  = mem_addr;
                    wdata_m_d = '0;
                    wstrb_m_d = 4'h0;
                end
            end
            WR: begin
                if (mem_ready_m) begin
                    state_d   = IDLE;
                    deq       = 1'b1;
                    valid_m_d = 1'b0;
                    instr_m_d = 1'b0;
                    addr_m_d  = '0;
                    wdata_m_d = '0;
                    wstrb_m_d = 4'h0;
                end
            end
            RD: begin
                if (mem_ready_m) begin
                    state_d   = RESP;
                    valid_m_d = 1'b0;
                    instr_m_d = 1'b0;
                    addr_m_d  = '0;
                    wdata_m_d = '0;
                    wstrb_m_d = 4'h0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Upstream response. mem_ready is a registered one-cycle pulse for a
    // store ack, a forwarded read, or the cycle after memory returns read
    // data (which is also the RESP cycle). Data is zero whenever no read
    // response is being presented.
    always_comb begin
        ready_d = store_accept || fwd_accept || ((state_q == RD) && mem_ready_m);
        rdata_d = '0;
        if (fwd_accept) begin
            rdata_d = fwd_data;
        end else if ((state_q == RD) && mem_ready_m) begin
            rdata_d = mem_rdata_m;
        end
    end

    // State register. Reset discards buffered stores and any in-flight
    // memory request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            buf_addr_q  <= '{default: '0};
            buf_wdata_q <= '{default: '0};
            buf_wstrb_q <= '{default: '0};
            valid_m_q   <= 1'b0;
            instr_m_q   <= 1'b0;
            addr_m_q    <= '0;
            wdata_m_q   <= '0;
            wstrb_m_q   <= 4'h0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            buf_wstrb_q <= buf_wstrb_d;
            valid_m_q   <= valid_m_d;
            instr_m_q   <= instr_m_d;
            addr_m_q    <= addr_m_d;
            wdata_m_q   <= wdata_m_d;
            wstrb_m_q   <= wstrb_m_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mem_ready   = ready_q;
    assign mem_rdata   = rdata_q;
    assign mem_valid_m = valid_m_q;
    assign mem_instr_m = instr_m_q;
    assign mem_addr_m  = addr_m_q;
    assign mem_wdata_m = wdata_m_q;
    assign mem_wstrb_m = wstrb_m_q;
    assign wb_count    = count_q;
    assign wb_full     = full_q;
    assign wb_empty    = empty_q;

endmodule
